// File: rtl/dmem_lsu.sv
// Load/store unit: turns one RV32I byte-addressed load/store into word-aligned
// DMEM reads/writes (read-modify-write for sub-word, split for word-crossing).
module dmem_lsu #(
   parameter int DATA_LENGTH      = 32,
   parameter int DMEM_ADDR_LENGTH = 32,
   parameter int MEM_DEPTH        = 50
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_we,
   input  logic [2:0]                  req_funct3,
   input  logic [DMEM_ADDR_LENGTH-1:0] req_addr,
   input  logic [DATA_LENGTH-1:0]      req_wdata,
   output logic                        resp_valid,
   output logic [DATA_LENGTH-1:0]      resp_rdata,
   output logic                        resp_err,
   output logic [DMEM_ADDR_LENGTH-1:0] addr,
   output logic [DATA_LENGTH-1:0]      dataW,
   output logic                        MemRW,
   input  logic [DATA_LENGTH-1:0]      dataR
);
   localparam int WW = DMEM_ADDR_LENGTH - 2;
   localparam int NB = DATA_LENGTH / 8;
   localparam logic [WW:0] DEPTH_W = (WW+1)'(MEM_DEPTH);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP} state_t;
   state_t state_q, state_d;

   logic                   we_q;
   logic [2:0]             f3_q;
   logic [1:0]             off_q;
   logic                   cross_q;
   logic [WW-1:0]          w0_q;
   logic [DATA_LENGTH-1:0] wdata_q, lo_q, hi_q;

   logic                        resp_valid_q, resp_valid_d;
   logic                        resp_err_q, resp_err_d;
   logic [DATA_LENGTH-1:0]      resp_rdata_q, resp_rdata_d;
   logic [DMEM_ADDR_LENGTH-1:0] addr_q, addr_d;
   logic [DATA_LENGTH-1:0]      dataW_q, dataW_d;
   logic                        memrw_q, memrw_d;

   logic [1:0]    req_off;
   logic [2:0]    req_size;
   logic          req_cross;
   logic [WW-1:0] req_w0;
   logic [WW:0]   req_w1;
   logic          req_f3_ok;
   logic          req_err;

   always_comb begin
      req_off = req_addr[1:0];
      case (req_funct3[1:0])
         2'b00:   req_size = 3'd1;
         2'b01:   req_size = 3'd2;
         default: req_size = 3'd4;
      endcase
      req_cross = (({1'b0, req_off} + req_size) > 3'd4);
      req_w0    = req_addr[DMEM_ADDR_LENGTH-1:2];
      req_w1    = {1'b0, req_w0} + (WW+1)'(1);
      if (req_we)
         req_f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
      else
         req_f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      req_err = !req_f3_ok || ({1'b0, req_w0} >= DEPTH_W) || (req_cross && (req_w1 >= DEPTH_W));
   end

   // The word read in the current cycle is used directly, so lo/hi need no extra cycle
   logic [DATA_LENGTH-1:0]   lo_cur, hi_cur, win_lo, load_ext;
   logic [2*DATA_LENGTH-1:0] win, wsh, merged;
   logic [4:0]               sh;
   logic [NB-1:0]            size_mask;
   logic [2*NB-1:0]          bmask;
   logic [WW-1:0]            cur_w0, cur_w1;

   assign lo_cur = (state_q == RD_LO) ? dataR : lo_q;
   assign hi_cur = (state_q == RD_HI) ? dataR : hi_q;
   assign win    = {hi_cur, lo_cur};
   assign sh     = {off_q, 3'b000};
   assign win_lo = DATA_LENGTH'(win >> sh);
   assign wsh    = {{DATA_LENGTH{1'b0}}, wdata_q} << sh;
   assign bmask  = {{NB{1'b0}}, size_mask} << off_q;
   assign cur_w0 = (state_q == IDLE) ? req_w0 : w0_q;
   assign cur_w1 = cur_w0 + WW'(1);

   always_comb begin
      case (f3_q[1:0])
         2'b00:   size_mask = NB'(1);
         2'b01:   size_mask = NB'(3);
         default: size_mask = '1;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2*NB; gi++) begin : g_merge
         assign merged[8*gi +: 8] = bmask[gi] ? wsh[8*gi +: 8] : win[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      case (f3_q)
         3'b000:  load_ext = {{(DATA_LENGTH-8){win_lo[7]}}, win_lo[7:0]};
         3'b001:  load_ext = {{(DATA_LENGTH-16){win_lo[15]}}, win_lo[15:0]};
         3'b100:  load_ext = {{(DATA_LENGTH-8){1'b0}}, win_lo[7:0]};
         3'b101:  load_ext = {{(DATA_LENGTH-16){1'b0}}, win_lo[15:0]};
         default: load_ext = win_lo;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_err)
                  state_d = RESP;
               else if (req_we && req_funct3 == 3'b010 && req_off == 2'b00)
                  state_d = WR_LO;
               else
                  state_d = RD_LO;
            end
         end
         RD_LO:   state_d = cross_q ? RD_HI : (we_q ? WR_LO : RESP);
         RD_HI:   state_d = we_q ? WR_LO : RESP;
         WR_LO:   state_d = cross_q ? WR_HI : RESP;
         WR_HI:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered, so they are computed from the state being entered
   always_comb begin
      addr_d       = addr_q;
      dataW_d      = dataW_q;
      memrw_d      = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      case (state_d)
         RD_LO: addr_d = {cur_w0, 2'b00};
         RD_HI: addr_d = {cur_w1, 2'b00};
         WR_LO: begin
            addr_d  = {cur_w0, 2'b00};
            memrw_d = 1'b1;
            dataW_d = (state_q == IDLE) ? req_wdata : merged[DATA_LENGTH-1:0];
         end
         WR_HI: begin
            addr_d  = {cur_w1, 2'b00};
            memrw_d = 1'b1;
            dataW_d = merged[2*DATA_LENGTH-1:DATA_LENGTH];
         end
         RESP: begin
            resp_valid_d = 1'b1;
            resp_err_d   = (state_q == IDLE);
            if (!we_q && (state_q inside {RD_LO, RD_HI}))
               resp_rdata_d = load_ext;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= '0;
         off_q        <= '0;
         cross_q      <= 1'b0;
         w0_q         <= '0;
         wdata_q      <= '0;
         lo_q         <= '0;
         hi_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         addr_q       <= '0;
         dataW_q      <= '0;
         memrw_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         addr_q       <= addr_d;
         dataW_q      <= dataW_d;
         memrw_q      <= memrw_d;
         if (state_q == RD_LO) lo_q <= dataR;
         if (state_q == RD_HI) hi_q <= dataR;
         if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= req_off;
            cross_q <= req_cross;
            w0_q    <= req_w0;
            wdata_q <= req_wdata;
         end
      end
   end

   assign req_ready  = (state_q == IDLE) && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign addr       = addr_q;
   assign dataW      = dataW_q;
   assign MemRW      = memrw_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: word DMEM model sampling on negedge, byte-level reference
// model, directed cases from the test plan plus random loads/stores.
module tb_dmem_lsu;
   localparam int DL    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 50;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [DL-1:0] req_wdata;
   logic          resp_valid, resp_err;
   logic [DL-1:0] resp_rdata;
   logic [AW-1:0] addr;
   logic [DL-1:0] dataW, dataR;
   logic          MemRW;

   int total = 0;
   int bad   = 0;

   logic [31:0] dmem   [0:DEPTH-1];
   logic [31:0] refmem [0:DEPTH-1];
   logic [31:0] hist   [0:31];
   logic [31:0] last_rd;
   logic        load_en = 1'b0;
   int          load_idx = 0;
   logic [31:0] load_val = '0;

   always #5 clk = ~clk;

   dmem_lsu #(.DATA_LENGTH(DL), .DMEM_ADDR_LENGTH(AW), .MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .addr(addr), .dataW(dataW), .MemRW(MemRW), .dataR(dataR)
   );

   // DMEM: writes commit and reads sample on the negedge
   always @(negedge clk) begin
      if (load_en)
         dmem[load_idx] <= load_val;
      else if (MemRW && int'(addr[31:2]) < DEPTH)
         dmem[int'(addr[31:2])] <= dataW;
      dataR <= (int'(addr[31:2]) < DEPTH) ? dmem[int'(addr[31:2])] : 32'h0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] val);
      @(posedge clk);
      load_en  = 1'b1;
      load_idx = idx;
      load_val = val;
      refmem[idx] = val;
      @(negedge clk);
      #1 load_en = 1'b0;
   endtask

   // Reference: byte-addressed view of memory, latency from the access count
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic err, output int lat,
                        output logic [31:0] rd, output int nwr);
      int size, nw;
      bit legal;
      longint lo_w, hi_w, ba;
      logic [7:0] b;
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      lo_w  = longint'(a) >> 2;
      hi_w  = (longint'(a) + size - 1) >> 2;
      err   = !legal || lo_w >= DEPTH || hi_w >= DEPTH;
      rd    = '0;
      nwr   = 0;
      if (err) begin
         lat = 1;
      end else begin
         nw = (hi_w != lo_w) ? 2 : 1;
         if (!we) begin
            lat = nw + 1;
            for (int i = 0; i < size; i++) begin
               ba = longint'(a) + i;
               b  = refmem[int'(ba >> 2)][8*int'(ba % 4) +: 8];
               rd[8*i +: 8] = b;
            end
            if (f3 == 3'd0 && rd[7])  rd[31:8]  = '1;
            if (f3 == 3'd1 && rd[15]) rd[31:16] = '1;
         end else begin
            lat = (f3 == 3'd2 && a[1:0] == 2'b00) ? 2 : 2*nw + 1;
            nwr = nw;
            for (int i = 0; i < size; i++) begin
               ba = longint'(a) + i;
               refmem[int'(ba >> 2)][8*int'(ba % 4) +: 8] = wd[8*i +: 8];
            end
         end
      end
   endtask

   task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
      logic        err, got, moved;
      int          lat, nwr, n, writes;
      logic [31:0] rd, a_before;
      longint      w0, w1;
      model(we, f3, a, wd, err, lat, rd, nwr);
      @(negedge clk);
      check({tag, ".ready"}, 32'(req_ready), 32'd1);
      a_before   = addr;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      n = 0; got = 1'b0; writes = 0; moved = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         hist[n] = addr;
         if (MemRW) writes++;
         if (addr !== a_before) moved = 1'b1;
         if (resp_valid) got = 1'b1;
      end
      req_valid = 1'b0;
      last_rd   = resp_rdata;
      check({tag, ".latency"}, 32'(n), 32'(lat));
      check({tag, ".rdata"}, resp_rdata, rd);
      check({tag, ".err"}, 32'(resp_err), 32'(err));
      check({tag, ".writes"}, 32'(writes), 32'(nwr));
      if (err) check({tag, ".addr_moved"}, 32'(moved), 32'd0);
      w0 = longint'(a) >> 2;
      w1 = w0 + 1;
      if (w0 < DEPTH) check({tag, ".mem_w0"}, dmem[int'(w0)], refmem[int'(w0)]);
      if (w1 < DEPTH) check({tag, ".mem_w1"}, dmem[int'(w1)], refmem[int'(w1)]);
      $display("txn %s we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d cycles=%0d",
               tag, we, f3, a, wd, resp_rdata, resp_err, n);
      @(negedge clk);
      check({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < DEPTH; i++) set_word(i, $urandom);
      @(negedge clk);
      check("reset.ready", 32'(req_ready), 32'd0);
      check("reset.valid", 32'(resp_valid), 32'd0);
      check("reset.memrw", 32'(MemRW), 32'd0);
      check("reset.addr", addr, 32'd0);
      check("reset.dataW", dataW, 32'd0);
      rst = 1'b0;

      set_word(0, 32'h8899AABB);
      txn("lb", 1'b0, 3'b000, 32'h1, 32'h0);
      check("lb.const", last_rd, 32'hFFFFFFAA);
      txn("lbu", 1'b0, 3'b100, 32'h1, 32'h0);
      check("lbu.const", last_rd, 32'h000000AA);

      set_word(0, 32'h44332211);
      set_word(1, 32'h88776655);
      txn("lw_x", 1'b0, 3'b010, 32'h3, 32'h0);
      check("lw_x.const", last_rd, 32'h77665544);
      check("lw_x.rd0", hist[1], 32'h0);
      check("lw_x.rd1", hist[2], 32'h4);

      txn("sh", 1'b1, 3'b001, 32'h6, 32'h0000BEEF);
      check("sh.word1", dmem[1], 32'hBEEF6655);

      set_word(1, 32'h88776655);
      txn("sw_x", 1'b1, 3'b010, 32'h2, 32'hDEADBEEF);
      check("sw_x.word0", dmem[0], 32'hBEEF2211);
      check("sw_x.word1", dmem[1], 32'h8877DEAD);

      txn("err_f3", 1'b0, 3'b011, 32'h0, 32'h0);
      txn("err_lw", 1'b0, 3'b010, 32'(4*DEPTH), 32'h0);
      txn("err_lh", 1'b0, 3'b001, 32'(4*DEPTH-1), 32'h0);
      txn("err_sbu", 1'b1, 3'b100, 32'h8, 32'h12345678);
      txn("err_far", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0);

      // Reset in the middle of a crossing store
      set_word(0, 32'h44332211);
      set_word(1, 32'h88776655);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 check("rst.in_write", 32'(MemRW), 32'd1);
      rst = 1'b1;
      #1;
      check("rst.ready", 32'(req_ready), 32'd0);
      check("rst.valid", 32'(resp_valid), 32'd0);
      check("rst.rdata", resp_rdata, 32'd0);
      check("rst.err", 32'(resp_err), 32'd0);
      check("rst.addr", addr, 32'd0);
      check("rst.dataW", dataW, 32'd0);
      check("rst.memrw", 32'(MemRW), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst.no_resp", 32'(resp_valid), 32'd0);
      end
      rst = 1'b0;
      txn("lw_after_rst", 1'b0, 3'b010, 32'h4, 32'h0);
      check("lw_after_rst.const", last_rd, 32'h88776655);

      for (int t = 0; t < 300; t++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH+7));
         txn("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end

      for (int i = 0; i < DEPTH; i++) check("final.mem", dmem[i], refmem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that sits between the core's execute stage and the word-addressed DMEM, acting as the initiator on the DMEM port. It accepts one RV32I load or store per transaction (LB/LH/LW/LBU/LHU/SB/SH/SW) at any byte address. It converts each one into word-aligned DMEM reads and writes. Sub-word stores become read-modify-write sequences. Accesses that cross a word boundary are split into two word accesses. The result or error is returned to the core through a valid/ready handshake.

## Interface
- DATA_LENGTH, 32, data and word width
- DMEM_ADDR_LENGTH, 32, byte address width
- MEM_DEPTH, 50, DMEM depth in words; word index >= MEM_DEPTH is out of range
- clk  in  1  single clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  high only in IDLE and rst low; transfer on posedge when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  DMEM_ADDR_LENGTH  byte address
- req_wdata  in  DATA_LENGTH  store data (low bytes used for B/H)
- resp_valid  out  1  one-cycle pulse, transaction complete
- resp_rdata  out  DATA_LENGTH  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 or out-of-range word, qualified by resp_valid
- addr  out  DMEM_ADDR_LENGTH  DMEM word address (bits [1:0] always 00)
- dataW  out  DATA_LENGTH  DMEM write data
- MemRW  out  1  DMEM write enable
- dataR  in  DATA_LENGTH  DMEM read data; valid at the posedge ending a read cycle

## Operation
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP. Every non-IDLE state lasts exactly one cycle.
- On accept, latch the request fields. Derived values:
  - off = addr[1:0]
  - size = 1, 2 or 4 bytes
  - cross = (off + size > 4)
  - w0 = addr[31:2]
  - w1 = w0 + 1
- Errors:
  - Conditions: funct3 is illegal for the direction (store with 1xx or 011; load with 011, 110 or 111), or w0 >= MEM_DEPTH, or cross && w1 >= MEM_DEPTH.
  - Response: IDLE -> RESP with resp_err=1. No DMEM access occurs.
- Load path: IDLE -> RD_LO -> (cross ? RD_HI) -> RESP.
  - lo is captured from dataR at the end of RD_LO; hi is captured at the end of RD_HI.
  - win = {hi, lo} >> (8*off). Take the low size bytes.
  - Sign-extend for B/H; zero-extend for BU/HU.
- Store path:
  - Aligned SW (off=0): IDLE -> WR_LO -> RESP. No read.
  - Otherwise: IDLE -> RD_LO -> (cross ? RD_HI) -> WR_LO -> (cross ? WR_HI) -> RESP.
- Merge rule (little-endian): byte lane k of the 64-bit window {hi,lo} is replaced by store byte (k - off) for off <= k < off+size. All other lanes keep the read value.
- DMEM port drive per state:
  - RD_*: addr = w0 or w1 (times 4), MemRW=0.
  - WR_*: addr = w0 or w1 (times 4), MemRW=1, dataW = merged lo or hi word.
  - All other states: MemRW=0; addr and dataW hold their last values.
- All DMEM outputs and resp_* are registered.

## Timing
- Accept edge = T0. resp_valid is high in the cycle after the final access state:
  - Aligned load: T0+2
  - Crossing load: T0+3
  - Aligned SW: T0+2
  - Aligned SB/SH: T0+3
  - Crossing store: T0+5
  - Error: T0+1
- DMEM commits writes and samples reads on negedge, mid-cycle of the RD_*/WR_* state.
- After RESP, the FSM returns to IDLE. req_ready is high the next cycle, giving at most one transaction per (latency+1) cycles.
- resp_valid is not back-pressured. The core must take the response in its RESP cycle.
- req_* inputs are ignored outside IDLE.
- Reset:
  - Asserting rst at any time forces IDLE immediately.
  - All outputs go to 0: req_ready, resp_valid, resp_rdata, resp_err, addr, dataW, MemRW.
  - A store interrupted between WR_LO and WR_HI leaves only the low word updated. This is acceptable.
  - No response is generated for an aborted transaction.

## Test plan
- DMEM word 0 = 0x8899AABB; LB addr 0x1 -> resp_rdata 0xFFFFFFAA at T0+2; LBU addr 0x1 -> 0x000000AA.
- Words 0/1 = 0x44332211/0x88776655; LW addr 0x3 -> 0x77665544 at T0+3; exactly two reads, to 0x0 then 0x4, with MemRW low throughout.
- SH wdata 0x0000BEEF to addr 0x6 with word 1 = 0x88776655 -> word 1 becomes 0xBEEF6655, resp_valid at T0+3, resp_rdata 0.
- SW 0xDEADBEEF to addr 0x2 with words 0/1 = 0x44332211/0x88776655 -> words become 0xBEEF2211/0x8877DEAD, resp at T0+5.
- Illegal requests, each at T0+1 with no MemRW pulse and no DMEM address change:
  - funct3=011 load -> resp_err=1.
  - LW addr 4*MEM_DEPTH -> resp_err=1.
  - LH addr 4*MEM_DEPTH-1 (crossing) -> resp_err=1.
- Assert rst during WR_LO of a crossing store:
  - Immediately: all outputs 0, no resp_valid.
  - After release: req_ready=1 and a new LW completes normally.
